memory_access_unit: RTL

//   Downstream of the register unit: takes the memory register value (offset) and the selected

---
 rtl/memory_access_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/memory_access_unit.sv
// Memory access unit: forms a segmented physical address and runs one read or write
// handshake with the memory system, aborting after TIMEOUT cycles without acknowledge.
module memory_access_unit #(
  parameter int ADDR_W    = 20,
  parameter int SEG_SHIFT = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              r,
  input  logic              req,
  input  logic              we,
  input  logic [15:0]       seg,
  input  logic [15:0]       off,
  input  logic [15:0]       wdata,
  input  logic              moe,
  inout  wire  [15:0]       bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_sum;

  // Carry out of the physical address width is discarded, so addresses wrap.
  always_comb begin
    addr_sum = ADDR_W'({seg, {SEG_SHIFT{1'b0}}}) + ADDR_W'(off);
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d     = S_ACCESS;
          busy_d      = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = we;
          mem_addr_d  = addr_sum;
          mem_wdata_d = wdata;
          cnt_d       = 8'd0;
        end
      end
      S_ACCESS: begin
        // An acknowledge in the same cycle as the timeout still completes the access.
        if (mem_ack) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
            state_d   = S_ERR;
            err_d     = 1'b1;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end
      end
      S_DONE, S_ERR: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      rdata_q     <= 16'h0000;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // The bus driver depends only on moe, never on the transaction state.
  assign bus = moe ? rdata_q : 16'bz;

endmodule
